// File: rtl/branch_pc_ctrl.sv
// PC-source select for the fetch stage with a 2-bit-counter branch history table.
// Execute-stage mispredict recovery has highest priority; decode jumps and predicted branches follow.
module branch_pc_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             id_valid,
  input  logic             id_is_jump,
  input  logic             id_is_branch,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_b_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_b_target,
  output logic [1:0]       pc_src,
  output logic [31:0]      b_addr,
  output logic             id_pred_taken,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned Entries = 2 ** IDX_W;

  typedef enum logic {StNormal, StRecover} state_e;

  state_e           state_q, state_d;
  logic [1:0]       bht_q [Entries];
  logic [1:0]       bht_d [Entries];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] id_idx, ex_idx;
  logic             ex_resolve, mispred, pred_raw;
  logic [31:0]      rec_addr;
  logic             unused_id_pc_bits;

  assign id_idx            = id_pc[IDX_W+1:2];
  assign ex_idx            = ex_pc[IDX_W+1:2];
  assign unused_id_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

  assign ex_resolve = ex_valid & ex_is_branch;
  assign mispred    = ex_resolve & (ex_taken != ex_pred_taken);
  assign rec_addr   = ex_taken ? ex_b_target : ex_pc + 32'd4;
  assign pred_raw   = id_valid & id_is_branch & bht_q[id_idx][1];

  // Output select; decode-side choices are suppressed while the squashed slot sits in decode.
  always_comb begin
    pc_src        = 2'b00;
    b_addr        = id_b_target;
    flush         = 1'b0;
    id_pred_taken = pred_raw;
    if (rst) begin
      b_addr        = 32'd0;
      id_pred_taken = 1'b0;
    end else if (mispred) begin
      pc_src = 2'b10;
      b_addr = rec_addr;
      flush  = 1'b1;
    end else if (state_q == StNormal && !stall) begin
      if (id_valid && id_is_jump) begin
        pc_src = 2'b01;
      end else if (pred_raw) begin
        pc_src = 2'b10;
      end
    end
  end

  always_comb begin
    state_d       = mispred ? StRecover : StNormal;
    bht_d         = bht_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_resolve) begin
      if (ex_taken && bht_q[ex_idx] != 2'b11) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!ex_taken && bht_q[ex_idx] != 2'b00) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
      if (branch_cnt_q != {CNT_W{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    if (mispred && mispred_cnt_q != {CNT_W{1'b1}}) begin
      mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StNormal;
      bht_q         <= '{default: 2'b01};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed and random bench for branch_pc_ctrl against a behavioural model
// (per-index integer counters, saturating integer statistics, recovery flag).
module tb_branch_pc_ctrl;

  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, stall, id_valid, id_is_jump, id_is_branch;
  logic [31:0] id_pc, id_b_target, ex_pc, ex_b_target;
  logic ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [1:0] pc_src;
  logic [31:0] b_addr;
  logic id_pred_taken, flush;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_bht [16];
  int m_bcnt, m_mcnt;
  bit m_rec;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .id_valid(id_valid), .id_is_jump(id_is_jump), .id_is_branch(id_is_branch),
    .id_pc(id_pc), .id_b_target(id_b_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_b_target(ex_b_target),
    .pc_src(pc_src), .b_addr(b_addr), .id_pred_taken(id_pred_taken), .flush(flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
    m_rec  = 1'b0;
  endtask

  task automatic clear_inputs();
    stall = 0; id_valid = 0; id_is_jump = 0; id_is_branch = 0;
    id_pc = 0; id_b_target = 0;
    ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pred_taken = 0;
    ex_pc = 0; ex_b_target = 0;
  endtask

  // Compare all outputs with the model for the current inputs, then clock once.
  task automatic step();
    bit mis, pred;
    int idx, eidx;
    logic [1:0] e_src;
    logic [31:0] e_addr;
    #1;
    idx  = int'((id_pc >> 2) & 32'hF);
    eidx = int'((ex_pc >> 2) & 32'hF);
    mis  = ex_valid && ex_is_branch && (ex_taken != ex_pred_taken);
    pred = !rst && id_valid && id_is_branch && (m_bht[idx] >= 2);
    e_src  = 2'b00;
    e_addr = id_b_target;
    if (rst) e_addr = 0;
    else if (mis) begin
      e_src  = 2'b10;
      e_addr = ex_taken ? ex_b_target : ex_pc + 32'd4;
    end else if (!m_rec && !stall && id_valid && id_is_jump) e_src = 2'b01;
    else if (!m_rec && !stall && pred) e_src = 2'b10;
    chk("pc_src", 32'(pc_src), 32'(e_src));
    chk("b_addr", b_addr, e_addr);
    chk("flush", 32'(flush), 32'(!rst && mis));
    chk("id_pred_taken", 32'(id_pred_taken), 32'(pred));
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
    chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_rec = mis;
      if (ex_valid && ex_is_branch) begin
        m_bht[eidx] = ex_taken ? ((m_bht[eidx] < 3) ? m_bht[eidx] + 1 : 3)
                               : ((m_bht[eidx] > 0) ? m_bht[eidx] - 1 : 0);
        if (m_bcnt < CMAX) m_bcnt++;
      end
      if (mis && m_mcnt < CMAX) m_mcnt++;
    end
    #1;
  endtask

  task automatic ex_branch(input logic [31:0] pc, input bit taken, input bit pt,
                           input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_taken = taken;
    ex_pred_taken = pt; ex_b_target = tgt;
  endtask

  task automatic id_branch(input logic [31:0] pc, input logic [31:0] tgt);
    id_valid = 1; id_is_branch = 1; id_pc = pc; id_b_target = tgt;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    step();
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    rst = 0;

    // Cold lookup, then train 0x40 with two taken resolutions
    id_branch(32'h40, 32'h80); #1;
    chk("cold_pred", 32'(id_pred_taken), 32'd0);
    step();
    clear_inputs();
    ex_branch(32'h40, 1, 1, 32'h80); step(); step();
    clear_inputs();
    id_branch(32'h40, 32'h80); #1;
    chk("trained_pred", 32'(id_pred_taken), 32'd1);
    chk("trained_src", 32'(pc_src), 32'd2);
    chk("trained_addr", b_addr, 32'h80);
    step();

    // Not-taken mispredict, RECOVER blocks a jump for one cycle
    clear_inputs();
    ex_branch(32'h100, 0, 1, 32'h500); #1;
    chk("mp_src", 32'(pc_src), 32'd2);
    chk("mp_addr", b_addr, 32'h104);
    chk("mp_flush", 32'(flush), 32'd1);
    step();
    clear_inputs();
    id_valid = 1; id_is_jump = 1; id_b_target = 32'h77; #1;
    chk("recover_src", 32'(pc_src), 32'd0);
    step(); #1;
    chk("jump_src", 32'(pc_src), 32'd1);
    step();

    // Taken mispredict wins over stall and a decode jump
    ex_branch(32'h180, 1, 0, 32'h200); stall = 1; #1;
    chk("mp_stall_addr", b_addr, 32'h200);
    chk("mp_stall_flush", 32'(flush), 32'd1);
    step();
    chk("mp_cnt_inc", 32'(mispred_cnt), 32'd2);
    clear_inputs(); step();

    // Same-index read/update uses pre-update value; then saturate low
    id_branch(32'h30, 32'h90); ex_branch(32'h30, 1, 1, 32'h90); #1;
    chk("same_idx_pre", 32'(id_pred_taken), 32'd0);
    step();
    ex_valid = 0; #1;
    chk("same_idx_post", 32'(id_pred_taken), 32'd1);
    step();
    ex_branch(32'h30, 0, 0, 32'h90);
    repeat (6) step();
    ex_taken = 1; ex_pred_taken = 1; step();
    ex_valid = 0; #1;
    chk("sat_low", 32'(id_pred_taken), 32'd0);
    step();

    // Back-to-back mispredicts from a fresh reset
    clear_inputs(); rst = 1; step(); rst = 0;
    ex_branch(32'h10, 1, 0, 32'h300); step();
    ex_branch(32'h14, 0, 1, 32'h300); #1;
    chk("b2b_flush", 32'(flush), 32'd1);
    step();
    clear_inputs(); id_valid = 1; id_is_jump = 1; #1;
    chk("b2b_recover", 32'(pc_src), 32'd0);
    chk("b2b_mcnt", 32'(mispred_cnt), 32'd2);
    chk("b2b_bcnt", 32'(branch_cnt), 32'd2);
    step(); #1;
    chk("b2b_normal", 32'(pc_src), 32'd1);
    step();

    // Reset during RECOVER with a trained entry
    clear_inputs();
    ex_branch(32'h40, 1, 1, 32'h80); step(); step();
    ex_branch(32'h40, 0, 1, 32'h80); step();
    clear_inputs(); rst = 1; step(); rst = 0;
    id_branch(32'h40, 32'h80); #1;
    chk("rst_entry", 32'(id_pred_taken), 32'd0);
    chk("rst_bcnt", 32'(branch_cnt), 32'd0);
    chk("rst_mcnt", 32'(mispred_cnt), 32'd0);
    step();
    clear_inputs(); id_valid = 1; id_is_jump = 1; #1;
    chk("rst_normal", 32'(pc_src), 32'd1);
    step();

    // Random traffic; small PC range aliases BHT entries, rare resets
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      id_valid     = $urandom_range(0, 1);
      id_is_jump   = ($urandom_range(0, 4) == 0);
      id_is_branch = $urandom_range(0, 1);
      id_pc        = 32'($urandom_range(0, 31)) << 2;
      id_b_target  = $urandom;
      ex_valid     = $urandom_range(0, 1);
      ex_is_branch = ($urandom_range(0, 3) != 0);
      ex_taken     = $urandom_range(0, 1);
      ex_pred_taken = $urandom_range(0, 1);
      ex_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 31)) << 2;
      ex_b_target  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
